// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_alu_pkg
// Shared definitions for the multicycle execute-stage ALU (alu_mc) and its
// upstream controller (ctrl_unit): ALU operation codes, branch condition codes,
// FSM state encoding and a small op-classification helper.
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_alu_pkg;

  // ALU operation codes carried on alu_op
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b01010;
  localparam logic [4:0] ALU_OR   = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b01101;
  localparam logic [4:0] ALU_SLL  = 5'b01110;
  localparam logic [4:0] ALU_SRL  = 5'b01111;
  localparam logic [4:0] ALU_SRA  = 5'b10000;
  localparam logic [4:0] ALU_ADDR = 5'b11000;

  // Branch condition codes reported on branch_op (BR_NONE = not taken)
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GE   = 3'b100;
  localparam logic [2:0] BR_LTU  = 3'b101;
  localparam logic [2:0] BR_GEU  = 3'b110;

  // ALU sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4
  } alu_state_e;

  // Shifts are the only ops that take the serial path
  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Request/response bundle between ctrl_unit (master) and alu_mc (slave).
//   alu_en, alu_op, func3, branch_en, operand_a, operand_b : master -> slave
//   result, alu_valid, branch_op, busy                      : slave -> master
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             alu_en;
  logic [4:0]       alu_op;
  logic [2:0]       func3;
  logic             branch_en;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             alu_valid;
  logic [2:0]       branch_op;
  logic             busy;

  modport master (
    output alu_en, alu_op, func3, branch_en, operand_a, operand_b,
    input  result, alu_valid, branch_op, busy
  );

  modport slave (
    input  alu_en, alu_op, func3, branch_en, operand_a, operand_b,
    output result, alu_valid, branch_op, busy
  );
endinterface

// File: rtl/alu_mc_shifter.sv
// -----------------------------------------------------------------------------
// alu_serial_shifter
// One-bit-per-cycle shifter. Owns the shift register and remaining-step counter.
//   clk, rst      : clock, asynchronous active-low reset
//   load_i        : load load_data_i / load_cnt_i
//   step_i        : advance one bit and decrement the counter
//   dir_left_i    : 1 = shift left, 0 = shift right
//   arith_i       : right shifts replicate the MSB instead of filling 0
//   load_data_i   : value to shift
//   load_cnt_i    : number of steps (must be >= 1 when loaded)
//   data_o        : register contents after one more step (combinational),
//                   so the caller can capture the final value on the last step
//   done_o        : the step being taken now is the last one
// -----------------------------------------------------------------------------
module alu_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               dir_left_i,
  input  logic               arith_i,
  input  logic [WIDTH-1:0]   load_data_i,
  input  logic [SHAMT_W-1:0] load_cnt_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               done_o
);

  logic [WIDTH-1:0]   shift_q;
  logic [SHAMT_W-1:0] cnt_q;

  always_comb begin
    if (dir_left_i) data_o = {shift_q[WIDTH-2:0], 1'b0};
    else            data_o = {arith_i & shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
  end

  assign done_o = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      shift_q <= load_data_i;
      cnt_q   <= load_cnt_i;
    end else if (step_i) begin
      shift_q <= data_o;
      cnt_q   <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multicycle RV32I execute-stage ALU. Accepts a request from ctrl_unit, latches
// op/operands, computes add/sub/logic in one cycle and shifts serially (one bit
// per cycle), then presents a registered result with a one-cycle alu_valid
// pulse. Also resolves branch compares into a registered branch_op code.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   alu   : alu_mc_if slave port (request in, result/valid/branch_op/busy out)
// -----------------------------------------------------------------------------
module alu_mc
  import rv32i_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  alu
);

  alu_state_e       state_q, state_d;
  logic [4:0]       op_q;
  logic [2:0]       func3_q;
  logic             br_en_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic [2:0]       branch_op_q, branch_op_d;

  logic             accept;
  logic             sh_load, sh_step, sh_done;
  logic [WIDTH-1:0] sh_data;
  logic [WIDTH-1:0] alu_out;
  logic [2:0]       br_code;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = b_q[SHAMT_W-1:0];

  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sh_load),
    .step_i      (sh_step),
    .dir_left_i  (op_q == ALU_SLL),
    .arith_i     (op_q == ALU_SRA),
    .load_data_i (a_q),
    .load_cnt_i  (shamt),
    .data_o      (sh_data),
    .done_o      (sh_done)
  );

  // Single-cycle datapath; unknown codes (and shifts, handled elsewhere) give 0
  always_comb begin
    case (op_q)
      ALU_ADD, ALU_ADDR: alu_out = a_q + b_q;
      ALU_SUB:           alu_out = a_q - b_q;
      ALU_AND:           alu_out = a_q & b_q;
      ALU_OR:            alu_out = a_q | b_q;
      ALU_XOR:           alu_out = a_q ^ b_q;
      default:           alu_out = '0;
    endcase
  end

  // Branch comparator: taken code or BR_NONE (also for illegal func3 010/011)
  always_comb begin
    case (func3_q)
      3'b000:  br_code = (a_q == b_q)                   ? BR_EQ  : BR_NONE;
      3'b001:  br_code = (a_q != b_q)                   ? BR_NE  : BR_NONE;
      3'b100:  br_code = ($signed(a_q) <  $signed(b_q)) ? BR_LT  : BR_NONE;
      3'b101:  br_code = ($signed(a_q) >= $signed(b_q)) ? BR_GE  : BR_NONE;
      3'b110:  br_code = (a_q <  b_q)                   ? BR_LTU : BR_NONE;
      3'b111:  br_code = (a_q >= b_q)                   ? BR_GEU : BR_NONE;
      default: br_code = BR_NONE;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    branch_op_d = branch_op_q;
    accept      = 1'b0;
    sh_load     = 1'b0;
    sh_step     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (alu.alu_en) begin
          accept      = 1'b1;
          branch_op_d = BR_NONE;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (br_en_q) branch_op_d = br_code;
        if (is_shift_op(op_q)) begin
          if (shamt == '0) begin
            result_d = a_q;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            sh_load = 1'b1;
            state_d = S_SHIFT;
          end
        end else begin
          result_d = alu_out;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_SHIFT: begin
        sh_step = 1'b1;
        // Capture the post-step value on the final step
        if (sh_done) begin
          result_d = sh_data;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // A still-held alu_en belongs to the request just completed
        state_d = alu.alu_en ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!alu.alu_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      func3_q     <= '0;
      br_en_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      branch_op_q <= BR_NONE;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      branch_op_q <= branch_op_d;
      if (accept) begin
        op_q    <= alu.alu_op;
        func3_q <= alu.func3;
        br_en_q <= alu.branch_en;
        a_q     <= alu.operand_a;
        b_q     <= alu.operand_b;
      end
    end
  end

  assign alu.result    = result_q;
  assign alu.alu_valid = valid_q;
  assign alu.branch_op = branch_op_q;
  assign alu.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Directed bench for alu_mc. The driver pushes each request's expected result
// and branch code into a queue; an independent monitor pops and compares on
// every alu_valid pulse. The driver also checks completion latency and the
// hold/release handshake.
// -----------------------------------------------------------------------------
module tb_alu_mc;
  import rv32i_alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [2:0]       br;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  alu_mc_if #(.WIDTH(WIDTH)) bus ();

  alu_mc #(
    .WIDTH   (WIDTH),
    .SHAMT_W (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .alu (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && bus.alu_valid) begin
      check("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("branch_op", 64'(bus.branch_op), 64'(e.br));
      end
    end
  end

  // Issue one request and follow it to completion.
  //   exp_lat : rising edges after the accepting edge until alu_valid is seen
  //   hold    : cycles alu_en stays high after alu_valid
  task automatic do_req(input string name, input logic [4:0] op, input logic [2:0] f3,
                        input logic br_en, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res,
                        input logic [2:0] exp_br, input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    bit   got;
    // Wait for IDLE
    for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
    e.res = exp_res;
    e.br  = exp_br;
    exp_q.push_back(e);
    bus.alu_op    = op;
    bus.func3     = f3;
    bus.branch_en = br_en;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.alu_en    = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs; the running op must not see them
    bus.alu_op    = 5'b00000;
    bus.func3     = ~f3;
    bus.branch_en = ~br_en;
    bus.operand_a = ~a;
    bus.operand_b = b ^ 32'h0000_001F;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.alu_valid) got = 1'b1;
    end
    check({name, "_latency"}, got ? 64'(lat) : 64'hDEAD, 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(bus.alu_valid), 64'd0);
      check({name, "_hold_busy"}, 64'(bus.busy), 64'd1);
    end
    bus.alu_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_release_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.alu_en    = 1'b0;
    bus.alu_op    = '0;
    bus.func3     = '0;
    bus.branch_en = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_valid", 64'(bus.alu_valid), 64'd0);
    check("rst_branch_op", 64'(bus.branch_op), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Arithmetic and logic, with ADD held 3 cycles past valid
    do_req("add",  ALU_ADD,  3'b000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, BR_NONE, 1, 3);
    do_req("sub",  ALU_SUB,  3'b000, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, BR_NONE, 1, 0);
    do_req("addr", ALU_ADDR, 3'b000, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, BR_NONE, 1, 0);
    do_req("and",  ALU_AND,  3'b000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, BR_NONE, 1, 0);
    do_req("or",   ALU_OR,   3'b000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, BR_NONE, 1, 0);
    do_req("xor",  ALU_XOR,  3'b000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, BR_NONE, 1, 0);
    do_req("undef", 5'b00111, 3'b000, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, BR_NONE, 1, 0);

    // Serial shifts
    do_req("sra31",  ALU_SRA, 3'b000, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, BR_NONE, 32, 0);
    do_req("sll0",   ALU_SLL, 3'b000, 1'b0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, BR_NONE, 1, 0);
    do_req("sll4",   ALU_SLL, 3'b000, 1'b0, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, BR_NONE, 5, 0);
    do_req("srl1",   ALU_SRL, 3'b000, 1'b0, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, BR_NONE, 2, 0);
    do_req("sra1",   ALU_SRA, 3'b000, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'hC000_0000, BR_NONE, 2, 0);
    do_req("srl8",   ALU_SRL, 3'b000, 1'b0, 32'hF000_00FF, 32'h0000_0008, 32'h00F0_0000, BR_NONE, 9, 2);

    // Branch compares (ADD op alongside)
    do_req("br_lt",    ALU_ADD, 3'b100, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, BR_LT,   1, 0);
    do_req("br_ltu_n", ALU_ADD, 3'b110, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, BR_NONE, 1, 0);
    do_req("br_ill",   ALU_ADD, 3'b010, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, BR_NONE, 1, 0);
    do_req("br_eq",    ALU_ADD, 3'b000, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_000A, BR_EQ,   1, 0);
    do_req("br_geu",   ALU_ADD, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, BR_GEU,  1, 0);
    do_req("br_clr",   ALU_OR,  3'b000, 1'b0, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, BR_NONE, 1, 0);

    // Reset in the middle of a 20-step shift: no valid, async return to reset
    bus.alu_op    = ALU_SRL;
    bus.func3     = 3'b000;
    bus.branch_en = 1'b0;
    bus.operand_a = 32'hF000_0000;
    bus.operand_b = 32'h0000_0014;
    bus.alu_en    = 1'b1;
    @(posedge clk);               // accepting edge
    repeat (11) @(posedge clk);   // load edge + 10 shift steps
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_valid", 64'(bus.alu_valid), 64'd0);
    check("mid_rst_branch_op", 64'(bus.branch_op), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    bus.alu_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    do_req("srl20", ALU_SRL, 3'b000, 1'b0, 32'hF000_0000, 32'h0000_0014, 32'h0000_0F00, BR_NONE, 21, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multicycle RV32I execute-stage ALU, directly downstream of ctrl_unit.
- Consumes ctrl_unit's alu_op/alu_en handshake and the operands chosen by the port A/B muxes.
- Returns a registered result with a one-cycle alu_valid pulse, plus a branch_op code that ctrl_unit uses for branch resolution.
- Shifts run serially, one bit per cycle, to save area; all other ops take fixed latency.

Parameters:
- WIDTH, 32, datapath width.
- SHAMT_W, 5, shift-amount width, log2(WIDTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- alu_en  in  1  request from ctrl_unit; held high until alu_valid is seen.
- alu_op  in  5  operation code.
- func3  in  3  instruction func3, used for branch compare selection.
- branch_en  in  1  compare request; when high, branch_op is evaluated.
- operand_a  in  WIDTH  port A mux output.
- operand_b  in  WIDTH  port B mux output.
- result  out  WIDTH  registered result.
- alu_valid  out  1  one-cycle completion pulse.
- branch_op  out  3  registered branch condition code, 000 when not taken.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; result=0, alu_valid=0, branch_op=000, busy=0; shift counter=0.
- Op codes:
  - 00001 ADD; 00011 SUB (a-b, wraps mod 2^WIDTH).
  - 01010 AND; 01100 OR; 01101 XOR.
  - 01110 SLL; 01111 SRL; 10000 SRA.
  - 11000 ADDR (a+b, load/store address).
  - Any other code: result=0, completes like a non-shift op.
- FSM states: IDLE, EXEC, SHIFT, DONE, HOLD.
- IDLE: when alu_en=1, latch alu_op, operands, func3, branch_en → EXEC. Nothing is latched otherwise.
- EXEC:
  - Non-shift op: register result → DONE.
  - Shift op: load shift register with a, counter=b[4:0] (upper bits of b ignored) → SHIFT.
  - Shift amount 0: result=a → DONE directly.
- SHIFT:
  - Each cycle: shift one bit (SLL fills 0; SRL fills 0; SRA replicates bit WIDTH-1) and decrement counter.
  - When counter reaches 1 (last step), register result → DONE.
- DONE: alu_valid=1 for exactly one cycle.
  - alu_en=1 → HOLD.
  - alu_en=0 → IDLE.
- HOLD: alu_valid=0; wait for alu_en=0 → IDLE. A request is never restarted while alu_en is still held from the previous one.
- Latency, counted from the edge at which IDLE samples alu_en=1:
  - alu_valid is high during cycle N+2 for non-shift ops.
  - alu_valid is high during cycle N+2+shamt for shifts with shamt≥1 (shamt=0 → N+2).
- result holds its value until the next completion.
- Branch: when latched branch_en=1, branch_op is registered in EXEC from a vs b.
  - Taken codes: func3 000 EQ→001, 001 NE→010, 100 LT(signed)→011, 101 GE(signed)→100, 110 LTU→101, 111 GEU→110.
  - Not taken, or illegal func3 (010, 011) → 000.
  - Cleared to 000 when the next request is accepted.
- Inputs changing after acceptance have no effect on the running op.
- Reset asserted mid-shift: immediate return to IDLE; no alu_valid is issued.

Decomposition:
- Package rv32i_alu_pkg:
  - ALU op localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADDR).
  - Branch code localparams (BR_NONE, BR_EQ … BR_GEU).
  - FSM state encodings.
  - Shared with ctrl_unit.
- One sub-module, alu_serial_shifter: load, step, direction and arithmetic inputs; data and done outputs; owns the shift register and counter.
- Add/sub, logic ops and the comparator stay inline.

Test Plan:
- ADD: a=0x7FFFFFFF, b=1, op 00001 → result 0x80000000; alu_valid pulses once at N+2, then HOLD until alu_en drops.
- SUB wrap: a=0, b=1, op 00011 → result 0xFFFFFFFF. ADDR: a=0x1000, b=0xFFFFFFFC → result 0xFFC.
- SRA: a=0x80000000, b=0x1F, op 10000 → result 0xFFFFFFFF at N+33. SLL with b=0x20 (shamt 0) → result=a at N+2.
- Branch: func3 100, a=0xFFFFFFFF, b=1 → branch_op 011; func3 110, same operands → branch_op 000; func3 010 → 000.
- Handshake: alu_en held 3 cycles past alu_valid → exactly one valid pulse, no restart; a new alu_en after the drop is accepted normally.
- Reset pulse at shift step 10 of 20 → outputs return to reset values asynchronously; no alu_valid; the next request completes correctly.
